// File: rtl/enemy_patrol.sv
// Enemy controller: sweep/chase patrol with obstacle-aware turning, bomberman contact, explosion kill and timed respawn.
// All outputs registered (one cycle after inputs) except enemy_on, which is combinational from the VGA pixel.
module enemy_patrol #(
    parameter int INIT_X        = 300,
    parameter int INIT_Y        = 200,
    parameter int MIN_X         = 143,
    parameter int MAX_X         = 784,
    parameter int MIN_Y         = 34,
    parameter int MAX_Y         = 516,
    parameter int ENEMY_W       = 16,
    parameter int ENEMY_H       = 16,
    parameter int B_W           = 16,
    parameter int B_H           = 16,
    parameter int E_W           = 16,
    parameter int E_ARM         = 48,
    parameter int STEP_TICKS    = 1400000,
    parameter int RESPAWN_TICKS = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enemy_start,
    input  logic       chase_mode,
    input  logic [3:0] enemy_blocked,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic       explosion_scen,
    input  logic [9:0] e_x,
    input  logic [9:0] e_y,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] enemy_x,
    output logic [9:0] enemy_y,
    output logic [3:0] enemy_dir,
    output logic       enemy_alive,
    output logic       enemy_on,
    output logic       kill_pulse,
    output logic       death_signal
);
    typedef enum logic [1:0] {IDLE, MOVE, DEAD, HALT} state_t;

    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_R = 4'b0100;
    localparam logic [3:0] DIR_U = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;
    localparam logic [3:0] DIR_I = 4'b0000;

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
    localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN_TICKS - 1);

    localparam logic [11:0] L_WALL = 12'(MIN_X);
    localparam logic [11:0] R_WALL = 12'(MAX_X - ENEMY_W);
    localparam logic [11:0] T_WALL = 12'(MIN_Y);
    localparam logic [11:0] B_WALL = 12'(MAX_Y - ENEMY_H);
    localparam logic [11:0] EW     = 12'(ENEMY_W);
    localparam logic [11:0] EH     = 12'(ENEMY_H);
    localparam logic [11:0] BW     = 12'(B_W);
    localparam logic [11:0] BH     = 12'(B_H);
    localparam logic [11:0] XW     = 12'(E_W);
    localparam logic [11:0] XA     = 12'(E_ARM);

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [RW-1:0] resp_cnt, resp_n;
    logic [9:0]    x_n, y_n, step_x, step_y;
    logic [3:0]    dir_n, step_dir;
    logic          alive_n, kill_n, death_n;

    // Everything is compared at 12 bits with subtractions moved across, so nothing wraps at the screen edge.
    logic [11:0] ex, ey, bx, by, xx, xy, vx, vy, adx, ady;
    assign ex = {2'b00, enemy_x};
    assign ey = {2'b00, enemy_y};
    assign bx = {2'b00, b_x};
    assign by = {2'b00, b_y};
    assign xx = {2'b00, e_x};
    assign xy = {2'b00, e_y};
    assign vx = {2'b00, v_x};
    assign vy = {2'b00, v_y};

    logic open_l, open_r, open_u, open_d;
    assign open_l = !enemy_blocked[0] && (ex > L_WALL);
    assign open_r = !enemy_blocked[1] && (ex < R_WALL);
    assign open_u = !enemy_blocked[2] && (ey > T_WALL);
    assign open_d = !enemy_blocked[3] && (ey < B_WALL);

    logic contact, hit_h, hit_v, hit;
    assign contact = (bx < ex + EW) && (bx + BW > ex) && (by < ey + EH) && (by + BH > ey);
    assign hit_h   = (ex < xx + XW + XA) && (ex + EW + XA > xx) && (ey < xy + XW) && (ey + EH > xy);
    assign hit_v   = (ex < xx + XW) && (ex + EW > xx) && (ey < xy + XW + XA) && (ey + EH + XA > xy);
    assign hit     = explosion_scen && (hit_h || hit_v);

    assign enemy_on = enemy_alive && (vx >= ex) && (vx < ex + EW) && (vy >= ey) && (vy < ey + EH);

    logic x_pos, y_pos, dx_nz, dy_nz, x_first, x_open, y_open;
    assign x_pos   = bx > ex;
    assign y_pos   = by > ey;
    assign dx_nz   = bx != ex;
    assign dy_nz   = by != ey;
    assign adx     = x_pos ? bx - ex : ex - bx;
    assign ady     = y_pos ? by - ey : ey - by;
    assign x_first = adx >= ady;
    assign x_open  = x_pos ? open_r : open_l;
    assign y_open  = y_pos ? open_d : open_u;

    // Candidate position/direction if this cycle turns out to be a step cycle.
    always_comb begin
        step_x   = enemy_x;
        step_y   = enemy_y;
        step_dir = enemy_dir;
        if (!chase_mode) begin
            case (enemy_dir)
                DIR_L:   if (open_l) step_x = enemy_x - 10'd1; else step_dir = DIR_U;
                DIR_U:   if (open_u) step_y = enemy_y - 10'd1; else step_dir = DIR_R;
                DIR_R:   if (open_r) step_x = enemy_x + 10'd1; else step_dir = DIR_D;
                DIR_D:   if (open_d) step_y = enemy_y + 10'd1; else step_dir = DIR_L;
                default: step_dir = DIR_L;
            endcase
        end else if (dx_nz || dy_nz) begin
            if ((x_first && x_open) || (!x_first && !y_open && dx_nz && x_open)) begin
                step_x   = x_pos ? enemy_x + 10'd1 : enemy_x - 10'd1;
                step_dir = x_pos ? DIR_R : DIR_L;
            end else if ((!x_first && y_open) || (x_first && dy_nz && y_open)) begin
                step_y   = y_pos ? enemy_y + 10'd1 : enemy_y - 10'd1;
                step_dir = y_pos ? DIR_D : DIR_U;
            end else begin
                step_dir = DIR_I;
            end
        end
    end

    always_comb begin
        state_n = state;
        x_n     = enemy_x;
        y_n     = enemy_y;
        dir_n   = enemy_dir;
        tick_n  = tick;
        alive_n = enemy_alive;
        kill_n  = 1'b0;
        death_n = death_signal;
        resp_n  = resp_cnt;
        unique case (state)
            IDLE: if (enemy_start) begin
                state_n = MOVE;
                dir_n   = DIR_L;
                tick_n  = '0;
            end
            MOVE: if (hit) begin
                alive_n = 1'b0;
                kill_n  = 1'b1;
                dir_n   = DIR_I;
                resp_n  = '0;
                state_n = DEAD;
            end else if (contact) begin
                death_n = 1'b1;
                state_n = HALT;
            end else if (tick == TICK_LAST) begin
                tick_n = '0;
                x_n    = step_x;
                y_n    = step_y;
                dir_n  = step_dir;
            end else begin
                tick_n = tick + TW'(1);
            end
            DEAD: if (RESPAWN_TICKS != 0) begin
                if (resp_cnt == RESP_LAST) begin
                    x_n     = 10'(INIT_X);
                    y_n     = 10'(INIT_Y);
                    alive_n = 1'b1;
                    tick_n  = '0;
                    dir_n   = DIR_L;
                    state_n = MOVE;
                end else begin
                    resp_n = resp_cnt + RW'(1);
                end
            end
            HALT: if (hit) begin
                alive_n = 1'b0;
                kill_n  = 1'b1;
                dir_n   = DIR_I;
                resp_n  = '0;
                state_n = DEAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            enemy_x      <= 10'(INIT_X);
            enemy_y      <= 10'(INIT_Y);
            enemy_dir    <= DIR_I;
            tick         <= '0;
            enemy_alive  <= 1'b1;
            kill_pulse   <= 1'b0;
            death_signal <= 1'b0;
            resp_cnt     <= '0;
        end else begin
            state        <= state_n;
            enemy_x      <= x_n;
            enemy_y      <= y_n;
            enemy_dir    <= dir_n;
            tick         <= tick_n;
            enemy_alive  <= alive_n;
            kill_pulse   <= kill_n;
            death_signal <= death_n;
            resp_cnt     <= resp_n;
        end
    end
endmodule

// File: tb/tb_enemy_patrol.sv
// Directed bench for enemy_patrol: vector table for pixel/explosion geometry, hand sequences for movement, contact, kill and respawn.
`timescale 1ns/1ps
module tb_enemy_patrol;
    logic       clk = 1'b0;
    logic       reset;
    logic       enemy_start, chase_mode, explosion_scen;
    logic [3:0] enemy_blocked;
    logic [9:0] b_x, b_y, e_x, e_y, v_x, v_y;
    logic [9:0] enemy_x, enemy_y;
    logic [3:0] enemy_dir;
    logic       enemy_alive, enemy_on, kill_pulse, death_signal;

    always #5 clk = ~clk;

    enemy_patrol #(
        .INIT_X(300), .INIT_Y(200), .STEP_TICKS(4), .RESPAWN_TICKS(10)
    ) dut (
        .clk(clk), .reset(reset), .enemy_start(enemy_start), .chase_mode(chase_mode),
        .enemy_blocked(enemy_blocked), .b_x(b_x), .b_y(b_y), .explosion_scen(explosion_scen),
        .e_x(e_x), .e_y(e_y), .v_x(v_x), .v_y(v_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .enemy_dir(enemy_dir), .enemy_alive(enemy_alive), .enemy_on(enemy_on),
        .kill_pulse(kill_pulse), .death_signal(death_signal)
    );

    typedef struct {
        logic       expl;     // 0: pixel probe while idle at spawn, 1: explosion strobe while moving
        logic [9:0] px;
        logic [9:0] py;
        logic       exp_out;  // expected enemy_on or kill_pulse
    } vec_t;

    vec_t vecs [20];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        enemy_start    = 1'b0;
        chase_mode     = 1'b0;
        enemy_blocked  = 4'b0000;
        b_x = 10'd600; b_y = 10'd400;
        explosion_scen = 1'b0;
        e_x = 10'd0;   e_y = 10'd0;
        v_x = 10'd0;   v_y = 10'd0;
        #2;
        reset = 1'b0;
    endtask

    task automatic start_move();
        enemy_start = 1'b1;
        step();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 10'd300, 10'd200, 1'b1};
        vecs[1]  = '{1'b0, 10'd315, 10'd215, 1'b1};
        vecs[2]  = '{1'b0, 10'd310, 10'd210, 1'b1};
        vecs[3]  = '{1'b0, 10'd316, 10'd200, 1'b0};
        vecs[4]  = '{1'b0, 10'd299, 10'd200, 1'b0};
        vecs[5]  = '{1'b0, 10'd300, 10'd216, 1'b0};
        vecs[6]  = '{1'b0, 10'd300, 10'd199, 1'b0};
        vecs[7]  = '{1'b1, 10'd237, 10'd200, 1'b1};
        vecs[8]  = '{1'b1, 10'd236, 10'd200, 1'b0};
        vecs[9]  = '{1'b1, 10'd363, 10'd200, 1'b1};
        vecs[10] = '{1'b1, 10'd364, 10'd200, 1'b0};
        vecs[11] = '{1'b1, 10'd300, 10'd137, 1'b1};
        vecs[12] = '{1'b1, 10'd300, 10'd136, 1'b0};
        vecs[13] = '{1'b1, 10'd300, 10'd263, 1'b1};
        vecs[14] = '{1'b1, 10'd300, 10'd264, 1'b0};
        vecs[15] = '{1'b1, 10'd270, 10'd170, 1'b0};
        vecs[16] = '{1'b1, 10'd280, 10'd217, 1'b0};
        vecs[17] = '{1'b1, 10'd280, 10'd216, 1'b0};
        vecs[18] = '{1'b1, 10'd280, 10'd215, 1'b1};
        vecs[19] = '{1'b1, 10'd300, 10'd200, 1'b1};

        reset = 1'b1;
        enemy_start = 1'b0; chase_mode = 1'b0; enemy_blocked = 4'b0000;
        b_x = 10'd600; b_y = 10'd400; explosion_scen = 1'b0;
        e_x = 10'd0; e_y = 10'd0; v_x = 10'd0; v_y = 10'd0;
        #12;
        chk("reset_x", enemy_x, 300);
        chk("reset_y", enemy_y, 200);
        chk("reset_dir", enemy_dir, 0);
        chk("reset_alive", enemy_alive, 1);
        chk("reset_kill", kill_pulse, 0);
        chk("reset_death", death_signal, 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_reset();
            if (!vecs[i].expl) begin
                v_x = vecs[i].px; v_y = vecs[i].py;
                #1;
                chk($sformatf("vec%0d_enemy_on", i), enemy_on, vecs[i].exp_out);
            end else begin
                start_move();
                explosion_scen = 1'b1;
                e_x = vecs[i].px; e_y = vecs[i].py;
                step();
                explosion_scen = 1'b0;
                chk($sformatf("vec%0d_kill", i), kill_pulse, vecs[i].exp_out);
                chk($sformatf("vec%0d_alive", i), enemy_alive, !vecs[i].exp_out);
            end
        end

        // Sweep into the left wall, turn up, then climb one pixel per step.
        do_reset();
        start_move();
        chk("sweep_dir0", enemy_dir, 4'b1000);
        repeat (4) step();
        chk("sweep_x1", enemy_x, 299);
        repeat (624) step();
        chk("sweep_at_wall", enemy_x, 143);
        chk("sweep_dir_l", enemy_dir, 4'b1000);
        repeat (4) step();
        chk("wall_turn_dir", enemy_dir, 4'b0010);
        chk("wall_turn_x", enemy_x, 143);
        chk("wall_turn_y", enemy_y, 200);
        repeat (3) step();
        chk("up_wait_y", enemy_y, 200);
        step();
        chk("up_y1", enemy_y, 199);
        repeat (4) step();
        chk("up_y2", enemy_y, 198);
        chk("up_x_hold", enemy_x, 143);

        // Down-blocked does not affect leftward motion; left-blocked forces a turn.
        do_reset();
        start_move();
        enemy_blocked = 4'b1000;
        repeat (4) step();
        chk("blk_down_x", enemy_x, 299);
        chk("blk_down_dir", enemy_dir, 4'b1000);
        enemy_blocked = 4'b0001;
        repeat (4) step();
        chk("blk_left_x", enemy_x, 299);
        chk("blk_left_dir", enemy_dir, 4'b0010);

        // Chase along x, fall back to y, then stall.
        do_reset();
        chase_mode = 1'b1;
        b_x = 10'd340; b_y = 10'd210;
        start_move();
        repeat (4) step();
        chk("chase_x1", enemy_x, 301);
        chk("chase_dir_r", enemy_dir, 4'b0100);
        repeat (4) step();
        chk("chase_x2", enemy_x, 302);
        enemy_blocked = 4'b0010;
        repeat (4) step();
        chk("chase_sec_y", enemy_y, 201);
        chk("chase_sec_x", enemy_x, 302);
        chk("chase_dir_d", enemy_dir, 4'b0001);
        enemy_blocked = 4'b1010;
        repeat (4) step();
        chk("chase_idle_dir", enemy_dir, 0);
        chk("chase_idle_x", enemy_x, 302);
        chk("chase_idle_y", enemy_y, 201);

        // Equal magnitudes favour the x axis.
        do_reset();
        chase_mode = 1'b1;
        b_x = 10'd400; b_y = 10'd100;
        start_move();
        repeat (4) step();
        chk("tie_x", enemy_x, 301);
        chk("tie_y", enemy_y, 200);

        // Contact: edge-adjacent is not contact, overlap halts; kill still accepted in HALT.
        do_reset();
        start_move();
        b_x = 10'd316; b_y = 10'd200;
        step();
        chk("touch_edge_death", death_signal, 0);
        b_x = 10'd310; b_y = 10'd205;
        step();
        chk("contact_death", death_signal, 1);
        b_x = 10'd320;
        repeat (8) step();
        chk("halt_x", enemy_x, 300);
        chk("halt_y", enemy_y, 200);
        chk("halt_death_sticky", death_signal, 1);
        explosion_scen = 1'b1; e_x = 10'd300; e_y = 10'd200;
        step();
        explosion_scen = 1'b0;
        chk("halt_kill", kill_pulse, 1);
        chk("halt_kill_alive", enemy_alive, 0);
        chk("halt_kill_death", death_signal, 1);

        // Kill with a two-cycle strobe, then respawn after 10 cycles.
        do_reset();
        start_move();
        repeat (4) step();
        chk("pre_kill_x", enemy_x, 299);
        explosion_scen = 1'b1; e_x = 10'd236; e_y = 10'd200;
        step();
        chk("kill_pulse", kill_pulse, 1);
        chk("kill_alive", enemy_alive, 0);
        chk("kill_dir", enemy_dir, 0);
        v_x = 10'd305; v_y = 10'd205;
        #1;
        chk("dead_enemy_on", enemy_on, 0);
        step();
        explosion_scen = 1'b0;
        chk("kill_single_pulse", kill_pulse, 0);
        repeat (8) step();
        chk("respawn_early", enemy_alive, 0);
        chk("dead_frozen_x", enemy_x, 299);
        step();
        chk("respawn_alive", enemy_alive, 1);
        chk("respawn_x", enemy_x, 300);
        chk("respawn_y", enemy_y, 200);
        chk("respawn_dir", enemy_dir, 4'b1000);
        repeat (3) step();
        chk("respawn_tick_x", enemy_x, 300);
        step();
        chk("respawn_step_x", enemy_x, 299);

        // Explosion outranks contact in the same cycle.
        do_reset();
        start_move();
        b_x = 10'd310; b_y = 10'd205;
        explosion_scen = 1'b1; e_x = 10'd300; e_y = 10'd200;
        step();
        explosion_scen = 1'b0;
        chk("simul_kill", kill_pulse, 1);
        chk("simul_death", death_signal, 0);
        step();
        chk("simul_death_after", death_signal, 0);

        // Asynchronous reset mid-cycle clears a halted, moved enemy.
        do_reset();
        start_move();
        repeat (4) step();
        b_x = 10'd305; b_y = 10'd205;
        step();
        chk("pre_areset_death", death_signal, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_x", enemy_x, 300);
        chk("areset_death", death_signal, 0);
        chk("areset_dir", enemy_dir, 0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
